// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit beside the EX-stage ALU.
// Shift-add multiply and restoring divide over 32 cycles; EX is stalled until the result is ready.
module ex_muldiv_unit #(
    parameter int BIT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       funct3_i,
    input  logic [BIT_W-1:0] opa_i,
    input  logic [BIT_W-1:0] opb_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             valid_o,
    output logic [BIT_W-1:0] result_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [BIT_W-1:0] MIN_NEG = {1'b1, {(BIT_W-1){1'b0}}};

    state_t state, state_next;

    logic [2:0]         op;
    logic               neg_res;
    logic               neg_rem;
    logic [BIT_W-1:0]   mcand;
    logic [BIT_W-1:0]   dvsr;
    logic [BIT_W-1:0]   quo;
    logic [BIT_W-1:0]   rem;
    logic [2*BIT_W-1:0] prod;
    logic [5:0]         count;

    logic               issue;
    logic               a_signed, b_signed, a_neg, b_neg;
    logic [BIT_W-1:0]   mag_a, mag_b;
    logic               div_zero, div_ovf, fast;
    logic [BIT_W-1:0]   special;

    logic [BIT_W:0]     mul_sum;
    logic [2*BIT_W-1:0] prod_next;
    logic [BIT_W:0]     rem_sh;
    logic [BIT_W:0]     trial;
    logic [BIT_W-1:0]   rem_next, quo_next;
    logic [2*BIT_W-1:0] prod_fin;
    logic [BIT_W-1:0]   quo_fin, rem_fin, calc_result;

    // Operand decode at issue: signedness, magnitudes and the divide special cases.
    always_comb begin
        issue    = (state == IDLE) && start_i && !flush_i;
        a_signed = !((funct3_i == 3'b011) || (funct3_i[2] && funct3_i[0]));
        b_signed = a_signed && (funct3_i != 3'b010);
        a_neg    = a_signed && opa_i[BIT_W-1];
        b_neg    = b_signed && opb_i[BIT_W-1];
        mag_a    = a_neg ? -opa_i : opa_i;
        mag_b    = b_neg ? -opb_i : opb_i;
        div_zero = funct3_i[2] && (opb_i == '0);
        div_ovf  = funct3_i[2] && !funct3_i[0] && (opa_i == MIN_NEG) && (opb_i == '1);
        fast     = div_zero || div_ovf;
        if (div_zero)
            special = funct3_i[1] ? opa_i : '1;
        else
            special = funct3_i[1] ? '0 : MIN_NEG;
    end

    // One iteration of either datapath, plus sign correction of the final values.
    always_comb begin
        mul_sum   = prod[0] ? ({1'b0, prod[2*BIT_W-1:BIT_W]} + {1'b0, mcand})
                            : {1'b0, prod[2*BIT_W-1:BIT_W]};
        prod_next = {mul_sum, prod[BIT_W-1:1]};
        rem_sh    = {rem, quo[BIT_W-1]};
        trial     = rem_sh - {1'b0, dvsr};
        rem_next  = trial[BIT_W] ? rem_sh[BIT_W-1:0] : trial[BIT_W-1:0];
        quo_next  = {quo[BIT_W-2:0], !trial[BIT_W]};
        prod_fin  = neg_res ? -prod_next : prod_next;
        quo_fin   = neg_res ? -quo_next : quo_next;
        rem_fin   = neg_rem ? -rem_next : rem_next;
        if (op[2])
            calc_result = op[1] ? rem_fin : quo_fin;
        else if (op == 3'b000)
            calc_result = prod_fin[BIT_W-1:0];
        else
            calc_result = prod_fin[2*BIT_W-1:BIT_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue) state_next = fast ? DONE : CALC;
            CALC: begin
                if (flush_i)
                    state_next = IDLE;
                else if (count == 6'd31)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stall is combinational from start so EX is held in the issue cycle itself.
    always_comb begin
        stall_o = issue || (state == CALC);
        busy_o  = (state != IDLE);
        valid_o = (state == DONE) && !flush_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op       <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            mcand    <= '0;
            dvsr     <= '0;
            quo      <= '0;
            rem      <= '0;
            prod     <= '0;
            count    <= '0;
            result_o <= '0;
        end else if (issue) begin
            op      <= funct3_i;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            mcand   <= mag_a;
            dvsr    <= mag_b;
            prod    <= {{BIT_W{1'b0}}, mag_b};
            quo     <= mag_a;
            rem     <= '0;
            count   <= '0;
            if (fast)
                result_o <= special;
        end else if ((state == CALC) && !flush_i) begin
            count <= count + 6'd1;
            if (op[2]) begin
                rem <= rem_next;
                quo <= quo_next;
            end else begin
                prod <= prod_next;
            end
            if (count == 6'd31)
                result_o <= calc_result;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed RV32M vectors against an arithmetic
// model, with a per-cycle comparison of the handshake outputs.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] opa_i;
    logic [31:0] opb_i;
    logic        flush_i;
    logic        stall_o;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;

    int checks = 0;
    int passed = 0;
    logic [31:0] lastResult = 32'h0;

    ex_muldiv_unit #(.BIT_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .funct3_i (funct3_i),
        .opa_i    (opa_i),
        .opb_i    (opb_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    // Architectural RV32M result computed with plain 64-bit arithmetic.
    function automatic logic [31:0] modelResult(input logic [2:0] f, input logic [31:0] a,
                                                input logic [31:0] b);
        logic [63:0] p;
        int sa, sb, q;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        case (f)
            3'b000, 3'b001: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            3'b010:         p = {{32{a[31]}}, a} * {32'h0, b};
            3'b011:         p = {32'h0, a} * {32'h0, b};
            default:        p = 64'h0;
        endcase
        case (f)
            3'b000:                 return p[31:0];
            3'b001, 3'b010, 3'b011: return p[63:32];
            3'b100: begin
                if (b == 32'h0) return 32'hFFFFFFFF;
                if (ovf) return 32'h80000000;
                q = sa / sb;
                return q;
            end
            3'b101:  return (b == 32'h0) ? 32'hFFFFFFFF : a / b;
            3'b110: begin
                if (b == 32'h0) return a;
                if (ovf) return 32'h0;
                q = sa % sb;
                return q;
            end
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    function automatic logic isFast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 32'h0) || (!f[0] && (a == 32'h80000000) && (b == 32'hFFFFFFFF)));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected)
            passed++;
        else
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    // Expected timeline: cycles until the result appears, the held result and the DONE pulse.
    logic        mInFlight, mValid;
    int          mLeft;
    logic [31:0] mPending, mResult;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mInFlight <= 1'b0;
            mValid    <= 1'b0;
            mLeft     <= 0;
            mPending  <= 32'h0;
            mResult   <= 32'h0;
        end else if (mValid) begin
            mValid <= 1'b0;
        end else if (mInFlight) begin
            if (flush_i) begin
                mInFlight <= 1'b0;
            end else if (mLeft == 1) begin
                mInFlight <= 1'b0;
                mValid    <= 1'b1;
                mResult   <= mPending;
            end else begin
                mLeft <= mLeft - 1;
            end
        end else if (start_i && !flush_i) begin
            if (isFast(funct3_i, opa_i, opb_i)) begin
                mValid  <= 1'b1;
                mResult <= modelResult(funct3_i, opa_i, opb_i);
            end else begin
                mInFlight <= 1'b1;
                mLeft     <= 32;
                mPending  <= modelResult(funct3_i, opa_i, opb_i);
            end
        end
    end

    // Every cycle out of reset, the handshake outputs and held result must follow the timeline.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("cyc valid", 32'(valid_o), 32'(mValid && !flush_i));
            checkOutput("cyc busy", 32'(busy_o), 32'(mInFlight || mValid));
            checkOutput("cyc stall", 32'(stall_o),
                        32'(mInFlight || (!mValid && start_i && !flush_i)));
            checkOutput("cyc result", result_o, mResult);
        end
    end

    task automatic applyStimulus(input string name, input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] expLit, input int expLat);
        int lat;
        int stallCnt;
        logic got;
        checkOutput({name, " model"}, modelResult(f, a, b), expLit);
        @(posedge clk);
        #1;
        start_i  = 1'b1;
        funct3_i = f;
        opa_i    = a;
        opb_i    = b;
        @(negedge clk);
        stallCnt = stall_o ? 1 : 0;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (valid_o)
                got = 1'b1;
            else if (stall_o)
                stallCnt++;
        end
        checkOutput({name, " latency"}, 32'(lat), 32'(expLat));
        checkOutput({name, " result"}, result_o, expLit);
        checkOutput({name, " stall cycles"}, 32'(stallCnt), (expLat == 33) ? 32'd33 : 32'd1);
        lastResult = expLit;
    endtask

    initial begin
        rst      = 1'b1;
        start_i  = 1'b0;
        flush_i  = 1'b0;
        funct3_i = 3'b000;
        opa_i    = 32'h0;
        opb_i    = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset result", result_o, 32'h0);
        checkOutput("reset valid", 32'(valid_o), 32'h0);
        checkOutput("reset busy", 32'(busy_o), 32'h0);
        checkOutput("reset stall", 32'(stall_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus("MUL 7*-3",        3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        applyStimulus("MULH min*min",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
        applyStimulus("MULHSU -1*max",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        applyStimulus("MULHU max*max",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        applyStimulus("MULHU 2^16*2^16", 3'b011, 32'h00010000, 32'h00010000, 32'h00000001, 33);
        applyStimulus("MUL 2^16*2^16",   3'b000, 32'h00010000, 32'h00010000, 32'h00000000, 33);
        applyStimulus("DIV -20/3",       3'b100, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, 33);
        applyStimulus("REM -20/3",       3'b110, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 33);
        applyStimulus("DIVU 100/7",      3'b101, 32'd100,      32'd7,        32'd14,       33);
        applyStimulus("REMU 100/7",      3'b111, 32'd100,      32'd7,        32'd2,        33);
        applyStimulus("DIV 7/-2",        3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
        applyStimulus("REM 7/-2",        3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        33);
        applyStimulus("DIVU big",        3'b101, 32'hFFFFFFFF, 32'h80000001, 32'd1,        33);
        applyStimulus("REMU big",        3'b111, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 33);
        applyStimulus("DIV 5/0",         3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        applyStimulus("DIV ovf",         3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        applyStimulus("REM ovf",         3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
        applyStimulus("REMU 5/0",        3'b111, 32'd5,        32'd0,        32'd5,        1);

        // Flush ten cycles into CALC: no result, held output keeps the REMU value.
        @(posedge clk);
        #1;
        start_i  = 1'b1;
        funct3_i = 3'b101;
        opa_i    = 32'd1000;
        opb_i    = 32'd3;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        checkOutput("flush busy", 32'(busy_o), 32'h0);
        checkOutput("flush result held", result_o, lastResult);
        begin
            int pulses = 0;
            repeat (40) begin
                @(negedge clk);
                if (valid_o) pulses++;
            end
            checkOutput("flush no valid", 32'(pulses), 32'h0);
        end
        applyStimulus("MUL after flush", 3'b000, 32'd1234, 32'd1000, 32'd1234000, 33);

        // Asynchronous reset in the middle of CALC clears outputs before any edge.
        @(posedge clk);
        #1;
        start_i  = 1'b1;
        funct3_i = 3'b101;
        opa_i    = 32'd1000;
        opb_i    = 32'd3;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async rst result", result_o, 32'h0);
        checkOutput("async rst valid", 32'(valid_o), 32'h0);
        checkOutput("async rst busy", 32'(busy_o), 32'h0);
        checkOutput("async rst stall", 32'(stall_o), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus("DIVU after rst", 3'b101, 32'd100, 32'd7, 32'd14, 33);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
